// File: rtl/cpuclk_pkg.sv
// Shared definitions for the cpuclk consumer side: sequencer state codes and
// default release timing.
package cpuclk_pkg;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_HOLD    = 3'd1;
  localparam logic [2:0] ST_REL_MEM = 3'd2;
  localparam logic [2:0] ST_REL_IO  = 3'd3;
  localparam logic [2:0] ST_RUN     = 3'd4;

  typedef enum logic [2:0] {
    IDLE    = ST_IDLE,
    HOLD    = ST_HOLD,
    REL_MEM = ST_REL_MEM,
    REL_IO  = ST_REL_IO,
    RUN     = ST_RUN
  } seq_state_t;

  localparam int HOLD_CYCLES_DEF = 16;
  localparam int STAGE_GAP_DEF   = 4;
  localparam int TICK_DIV_DEF    = 4;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchroniser for a single asynchronous level, async active-low reset.
module sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [1:0] vld_pipe;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vld_pipe <= '0;
    else        vld_pipe <= {vld_pipe[0], d};
  end

  assign q = vld_pipe[1];

endmodule

// File: rtl/rst_sequencer.sv
// Qualifies the clock wizard lock, releases mem -> io -> cpu resets in order,
// and generates a slow-peripheral tick once the CPU is out of reset.
module rst_sequencer
  import cpuclk_pkg::*;
#(
  parameter int HOLD_CYCLES = HOLD_CYCLES_DEF,
  parameter int STAGE_GAP   = STAGE_GAP_DEF,
  parameter int TICK_DIV    = TICK_DIV_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic locked_i,
  input  logic sw_rst_req,
  output logic mem_rst_n,
  output logic io_rst_n,
  output logic cpu_rst_n,
  output logic ready,
  output logic tick
);

  localparam int CW = $clog2(max2(HOLD_CYCLES, STAGE_GAP) + 1);
  localparam int TW = $clog2(TICK_DIV);

  localparam logic [CW-1:0] CNT_MAX   = '1;
  localparam logic [CW-1:0] HOLD_END  = CW'(HOLD_CYCLES);
  localparam logic [CW-1:0] GAP_END   = CW'(STAGE_GAP - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

  seq_state_t    state;
  logic [CW-1:0] cnt;
  logic [TW-1:0] tcnt;
  logic          lock_s;

  sync2 u_lock_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (locked_i),
    .q     (lock_s)
  );

  function automatic logic [CW-1:0] cnt_inc(input logic [CW-1:0] c);
    return (c == CNT_MAX) ? c : c + CW'(1);
  endfunction

  // Lock loss outranks a software request; both drop every output on one edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      tcnt      <= '0;
      mem_rst_n <= 1'b0;
      io_rst_n  <= 1'b0;
      cpu_rst_n <= 1'b0;
      tick      <= 1'b0;
    end else begin
      tick <= 1'b0;
      tcnt <= '0;
      if (state != IDLE && !lock_s) begin
        state     <= IDLE;
        cnt       <= '0;
        mem_rst_n <= 1'b0;
        io_rst_n  <= 1'b0;
        cpu_rst_n <= 1'b0;
      end else if (sw_rst_req && (state == REL_MEM || state == REL_IO || state == RUN)) begin
        state     <= HOLD;
        cnt       <= CW'(1);
        mem_rst_n <= 1'b0;
        io_rst_n  <= 1'b0;
        cpu_rst_n <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (lock_s) begin
              state <= HOLD;
              cnt   <= CW'(1);
            end else begin
              cnt <= '0;
            end
          end
          HOLD: begin
            if (cnt == HOLD_END) begin
              state     <= REL_MEM;
              mem_rst_n <= 1'b1;
              cnt       <= '0;
            end else begin
              cnt <= cnt_inc(cnt);
            end
          end
          REL_MEM: begin
            if (cnt == GAP_END) begin
              state    <= REL_IO;
              io_rst_n <= 1'b1;
              cnt      <= '0;
            end else begin
              cnt <= cnt_inc(cnt);
            end
          end
          REL_IO: begin
            if (cnt == GAP_END) begin
              state     <= RUN;
              cpu_rst_n <= 1'b1;
              cnt       <= '0;
            end else begin
              cnt <= cnt_inc(cnt);
            end
          end
          RUN: begin
            tcnt <= (tcnt == TICK_LAST) ? '0 : tcnt + TW'(1);
            tick <= (tcnt == TICK_LAST);
          end
          default: begin
            state <= IDLE;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

  assign ready = cpu_rst_n;

endmodule

// File: tb/tb_rst_sequencer.sv
// Bench for rst_sequencer: directed timing tables plus randomized lock/sw traffic
// against a "cycles since qualification began" reference model.
module tb_rst_sequencer;
  import cpuclk_pkg::*;

  localparam int H = 16;
  localparam int G = 4;
  localparam int D = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic locked_i = 1'b0;
  logic sw_rst_req = 1'b0;
  logic mem_rst_n, io_rst_n, cpu_rst_n, ready, tick;
  logic [4:0] dut_out;

  always #5 clk = ~clk;

  rst_sequencer #(.HOLD_CYCLES(H), .STAGE_GAP(G), .TICK_DIV(D)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .locked_i   (locked_i),
    .sw_rst_req (sw_rst_req),
    .mem_rst_n  (mem_rst_n),
    .io_rst_n   (io_rst_n),
    .cpu_rst_n  (cpu_rst_n),
    .ready      (ready),
    .tick       (tick)
  );

  assign dut_out = {mem_rst_n, io_rst_n, cpu_rst_n, ready, tick};

  int n_chk  = 0;
  int n_pass = 0;

  // Model: two-deep history of locked_i, and t = edges since HOLD entry (-1 = idle).
  logic l1, l2;
  int   t;

  task automatic model_reset();
    l1 = 1'b0; l2 = 1'b0; t = -1;
  endtask

  task automatic model_edge(input logic lk, input logic sw);
    logic ls;
    ls = l2; l2 = l1; l1 = lk;
    if (t < 0)               begin if (ls) t = 0; end
    else if (!ls)            t = -1;
    else if (sw && t >= H)   t = 0;
    else                     t = t + 1;
  endtask

  function automatic logic [4:0] model_out();
    logic [4:0] r;
    r = '0;
    if (t >= 0) begin
      r[4] = (t >= H);
      r[3] = (t >= H + G);
      r[2] = (t >= H + 2*G);
      r[1] = r[2];
      r[0] = (t > H + 2*G) && (((t - H - 2*G) % D) == 0);
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [4:0] act, input logic [4:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s @%0t: got %b want %b (mem,io,cpu,ready,tick)", name, $time, act, exp);
  endtask

  task automatic step(input logic lk, input logic sw);
    locked_i = lk;
    sw_rst_req = sw;
    @(posedge clk);
    if (!rst_n) model_reset();
    else        model_edge(lk, sw);
    #1;
    check("model", dut_out, model_out());
  endtask

  typedef struct {
    int         e;
    logic [4:0] exp;
  } vec_t;

  vec_t pu[13];

  initial begin
    pu[0]  = '{0,  5'b00000};
    pu[1]  = '{17, 5'b00000};
    pu[2]  = '{18, 5'b10000};
    pu[3]  = '{21, 5'b10000};
    pu[4]  = '{22, 5'b11000};
    pu[5]  = '{25, 5'b11000};
    pu[6]  = '{26, 5'b11110};
    pu[7]  = '{29, 5'b11110};
    pu[8]  = '{30, 5'b11111};
    pu[9]  = '{31, 5'b11110};
    pu[10] = '{33, 5'b11110};
    pu[11] = '{34, 5'b11111};
    pu[12] = '{38, 5'b11111};

    model_reset();
    #2;
    check("reset_state", dut_out, 5'b00000);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0);
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) step(1'b0, 1'b0);

    // Power-up release timing
    for (int e = 0; e <= 38; e++) begin
      step(1'b1, 1'b0);
      for (int k = 0; k < 13; k++)
        if (pu[k].e == e) check($sformatf("powerup_e%0d", e), dut_out, pu[k].exp);
    end

    // Software reset in RUN
    step(1'b1, 1'b1);
    check("swrst_drop", dut_out, 5'b00000);
    for (int k = 1; k <= 24; k++) begin
      step(1'b1, 1'b0);
      if (k == 15) check("swrst_k15", dut_out, 5'b00000);
      if (k == 16) check("swrst_mem", dut_out, 5'b10000);
      if (k == 23) check("swrst_k23", dut_out, 5'b11000);
      if (k == 24) check("swrst_ready", dut_out, 5'b11110);
    end

    // Lock loss in RUN
    for (int k = 0; k < 6; k++) step(1'b1, 1'b0);
    for (int k = 0; k < 3; k++) step(1'b0, 1'b0);
    check("lockloss_3edges", dut_out, 5'b00000);
    for (int k = 0; k < 10; k++) step(1'b0, 1'b0);
    for (int e = 0; e < 30; e++) begin
      step(1'b1, 1'b0);
      if (e == 17) check("relock_e17", dut_out, 5'b00000);
      if (e == 18) check("relock_mem", dut_out, 5'b10000);
    end

    // Simultaneous lock loss and sw request: must land in IDLE, not HOLD
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    check("simul_drop", dut_out, 5'b00000);
    for (int j = 1; j <= 20; j++) begin
      step(1'b1, 1'b0);
      if (j == 16) check("simul_j16", dut_out, 5'b00000);
      if (j == 17) check("simul_mem", dut_out, 5'b10000);
    end

    // Lock glitch during HOLD
    for (int k = 0; k < 4; k++) step(1'b0, 1'b0);
    for (int e = 0; e <= 40; e++) begin
      step((e == 8 || e == 9) ? 1'b0 : 1'b1, 1'b0);
      if (e == 18) check("glitch_e18", dut_out, 5'b00000);
      if (e == 27) check("glitch_e27", dut_out, 5'b00000);
      if (e == 28) check("glitch_mem", dut_out, 5'b10000);
    end

    // Async reset mid-cycle, mid-sequence
    for (int k = 0; k < 4; k++) step(1'b0, 1'b0);
    for (int e = 0; e <= 20; e++) step(1'b1, 1'b0);
    #3 rst_n = 1'b0;
    model_reset();
    #1 check("async_rst", dut_out, 5'b00000);
    for (int k = 0; k < 3; k++) step(1'b1, 1'b0);
    rst_n = 1'b1;
    for (int e = 0; e <= 30; e++) begin
      step(1'b1, 1'b0);
      if (e == 17) check("rerun_e17", dut_out, 5'b00000);
      if (e == 18) check("rerun_mem", dut_out, 5'b10000);
      if (e == 25) check("rerun_e25", dut_out, 5'b11000);
      if (e == 26) check("rerun_ready", dut_out, 5'b11110);
      if (e == 30) check("rerun_tick", dut_out, 5'b11111);
    end

    // Randomized traffic against the model
    for (int i = 0; i < 4000; i++)
      step(($urandom_range(0, 99) < 97) ? 1'b1 : 1'b0,
           ($urandom_range(0, 39) == 0) ? 1'b1 : 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
